// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/execute control for a 16-bit ISA.
// Define SEQ_BRANCH_EN to enable BZ (op 1011) and JMP (op 1100); otherwise they run as NOPs.
module instr_sequencer #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [PC_W-1:0] rom_addr,
    input  logic [15:0]     rom_data,
    output logic [3:0]      da,
    output logic [3:0]      aa,
    output logic [3:0]      ba,
    output logic            mb,
    output logic            md,
    output logic            rw,
    output logic            mw,
    output logic            mm,
    output logic [2:0]      fs,
    input  logic            zero,
    output logic            mem_req,
    input  logic            mem_ack,
    output logic            busy,
    output logic            halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_ALU_MAX = 4'b1000;
    localparam logic [3:0] OP_LOAD    = 4'b1001;
    localparam logic [3:0] OP_STORE   = 4'b1010;
    localparam logic [3:0] OP_HALT    = 4'b1111;

    state_t          r_state;
    state_t          w_nextState;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_nextPc;
    logic [PC_W-1:0] w_pcInc;
    logic [15:0]     r_ir;
    logic [3:0]      w_op;

    assign w_op    = r_ir[15:12];
    assign w_pcInc = r_pc + {{(PC_W-1){1'b0}}, 1'b1};

`ifdef SEQ_BRANCH_EN
    localparam logic [3:0] OP_BZ  = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;

    logic [PC_W-1:0] w_offset;
    logic [PC_W-1:0] w_branchPc;
    logic [PC_W-1:0] w_jumpPc;

    // Narrow PCs only need the low bits of the sign-extended offset.
    generate
        if (PC_W > 8) begin : g_offsetWide
            assign w_offset = {{(PC_W-8){r_ir[7]}}, r_ir[7:0]};
        end else begin : g_offsetNarrow
            assign w_offset = r_ir[PC_W-1:0];
        end
        if (PC_W > 16) begin : g_jumpWide
            assign w_jumpPc = {{(PC_W-16){1'b0}}, r_ir};
        end else begin : g_jumpNarrow
            assign w_jumpPc = r_ir[PC_W-1:0];
        end
    endgenerate

    assign w_branchPc = r_pc + w_offset;
`else
    logic w_unusedZero;
    assign w_unusedZero = zero;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
        end else begin
            r_state <= w_nextState;
            r_pc    <= w_nextPc;
            if (r_state == S_DECODE) begin
                r_ir <= rom_data;
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextPc    = r_pc;
        rw          = 1'b0;
        mw          = 1'b0;
        mm          = 1'b0;
        mem_req     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_nextState = S_FETCH;
                end
            end
            S_FETCH:  w_nextState = S_DECODE;
            S_DECODE: w_nextState = S_EXEC;
            S_EXEC: begin
                case (w_op)
                    OP_LOAD, OP_STORE: w_nextState = S_MEM;
                    OP_HALT:           w_nextState = S_HALT;
`ifdef SEQ_BRANCH_EN
                    OP_BZ: begin
                        w_nextState = S_FETCH;
                        w_nextPc    = zero ? w_branchPc : w_pcInc;
                    end
                    OP_JMP: begin
                        w_nextState = S_FETCH;
                        w_nextPc    = w_jumpPc;
                    end
`endif
                    // ALU ops write back here; every other opcode falls through as a NOP.
                    default: begin
                        w_nextState = S_FETCH;
                        w_nextPc    = w_pcInc;
                        rw          = (w_op <= OP_ALU_MAX);
                    end
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mm      = 1'b1;
                mw      = (w_op == OP_STORE);
                if (mem_ack) begin
                    rw          = (w_op == OP_LOAD);
                    w_nextState = S_FETCH;
                    w_nextPc    = w_pcInc;
                end
            end
            S_HALT:  w_nextState = S_HALT;
            default: w_nextState = S_IDLE;
        endcase
    end

    assign rom_addr = r_pc;
    assign da       = r_ir[11:8];
    assign aa       = r_ir[7:4];
    assign ba       = r_ir[3:0];
    assign mb       = (w_op == OP_ALU_MAX);
    assign md       = (w_op == OP_LOAD) || (w_op == OP_STORE);
    assign fs       = (w_op <= OP_ALU_MAX) ? w_op[2:0] : 3'b000;
    assign busy     = (r_state != S_IDLE) && (r_state != S_HALT);
    assign halted   = (r_state == S_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Testbench for instr_sequencer: hand-written vector table, corner-case sequences and a
// randomized program run against an instruction-level reference model.
module tb_instr_sequencer;

    localparam int PC_W = 8;
`ifdef SEQ_BRANCH_EN
    localparam bit BRANCH_EN = 1'b1;
`else
    localparam bit BRANCH_EN = 1'b0;
`endif

    localparam int K_ALU   = 0;
    localparam int K_LOAD  = 1;
    localparam int K_STORE = 2;
    localparam int K_NONE  = 3;
    localparam int K_HALT  = 4;

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] word;
        logic        zeroIn;
        int          ackDelay;
        logic [3:0]  da;
        logic [3:0]  aa;
        logic [3:0]  ba;
        logic [2:0]  fs;
        logic        mb;
        logic        md;
        int          kind;
        logic [7:0]  nextPc;
    } step_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [PC_W-1:0] rom_addr;
    logic [15:0]     rom_data;
    logic [3:0]      da;
    logic [3:0]      aa;
    logic [3:0]      ba;
    logic            mb;
    logic            md;
    logic            rw;
    logic            mw;
    logic            mm;
    logic [2:0]      fs;
    logic            zero;
    logic            mem_req;
    logic            mem_ack;
    logic            busy;
    logic            halted;

    logic [15:0] rom [0:255];
    int checks   = 0;
    int failures = 0;

    instr_sequencer #(.PC_W(PC_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .da       (da),
        .aa       (aa),
        .ba       (ba),
        .mb       (mb),
        .md       (md),
        .rw       (rw),
        .mw       (mw),
        .mm       (mm),
        .fs       (fs),
        .zero     (zero),
        .mem_req  (mem_req),
        .mem_ack  (mem_ack),
        .busy     (busy),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    // Synchronous instruction ROM: word appears one cycle after its address.
    always @(posedge clk) rom_data <= rom[rom_addr];

    function automatic logic [3:0] strobes();
        return {rw, mw, mem_req, mm};
    endfunction

    function automatic logic [31:0] allOuts();
        return {1'b0, rom_addr, da, aa, ba, fs, mb, md, rw, mw, mm, mem_req, busy, halted};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Instruction-level model: what one instruction at pc must show and where it leads.
    function automatic step_t predict(input logic [7:0] pc, input logic [15:0] word,
                                      input logic zeroIn, input int ackDelay);
        step_t s;
        int    op;
        op         = int'(word[15:12]);
        s.pc       = pc;
        s.word     = word;
        s.zeroIn   = zeroIn;
        s.ackDelay = ackDelay;
        s.da       = word[11:8];
        s.aa       = word[7:4];
        s.ba       = word[3:0];
        s.mb       = (op == 8);
        s.md       = (op == 9) || (op == 10);
        s.fs       = (op <= 8) ? word[14:12] : 3'd0;
        s.nextPc   = 8'(int'(pc) + 1);
        if (op <= 8)       s.kind = K_ALU;
        else if (op == 9)  s.kind = K_LOAD;
        else if (op == 10) s.kind = K_STORE;
        else if (op == 15) s.kind = K_HALT;
        else               s.kind = K_NONE;
        if (op == 15) s.nextPc = pc;
        if (BRANCH_EN && op == 11 && zeroIn) s.nextPc = 8'(int'(pc) + int'($signed(word[7:0])));
        if (BRANCH_EN && op == 12) s.nextPc = word[7:0];
        return s;
    endfunction

    function automatic step_t mk(input logic [15:0] word, input logic zeroIn, input int ackDelay,
                                 input logic [3:0] eDa, input logic [3:0] eAa, input logic [3:0] eBa,
                                 input logic [2:0] eFs, input logic eMb, input logic eMd,
                                 input int kind, input logic [7:0] nextPc);
        step_t s;
        s.pc = 8'd0; s.word = word; s.zeroIn = zeroIn; s.ackDelay = ackDelay;
        s.da = eDa; s.aa = eAa; s.ba = eBa; s.fs = eFs; s.mb = eMb; s.md = eMd;
        s.kind = kind; s.nextPc = nextPc;
        return s;
    endfunction

    // Entered and left at one time unit after a rising edge; state there is IDLE->FETCH done.
    task automatic resetAndStart();
        rst_n   = 1'b0;
        start   = 1'b0;
        mem_ack = 1'b0;
        zero    = 1'b0;
        #1;
        checkOutput("resetOutputs", allOuts(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b1;
        @(negedge clk);
        checkOutput("idleWait", {22'd0, busy, halted, rom_addr}, 32'd0);
        @(posedge clk); #1;
        start   = 1'b1;
        mem_ack = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Runs one instruction starting in its FETCH cycle, with noise on ignored inputs.
    task automatic applyStimulus(input step_t s);
        start   = 1'($urandom_range(0, 1));
        mem_ack = 1'($urandom_range(0, 1));
        zero    = 1'($urandom_range(0, 1));
        @(negedge clk);
        checkOutput("fetchAddr", {24'd0, rom_addr}, {24'd0, s.pc});
        checkOutput("fetchCtl", {26'd0, busy, halted, strobes()}, {26'd0, 2'b10, 4'b0000});
        @(posedge clk); #1;
        start   = 1'($urandom_range(0, 1));
        mem_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        checkOutput("decodeAddr", {24'd0, rom_addr}, {24'd0, s.pc});
        checkOutput("decodeCtl", {26'd0, busy, halted, strobes()}, {26'd0, 2'b10, 4'b0000});
        @(posedge clk); #1;
        start   = 1'($urandom_range(0, 1));
        mem_ack = 1'($urandom_range(0, 1));
        zero    = s.zeroIn;
        @(negedge clk);
        checkOutput("execFields", {15'd0, da, aa, ba, fs, mb, md},
                    {15'd0, s.da, s.aa, s.ba, s.fs, s.mb, s.md});
        checkOutput("execCtl", {26'd0, busy, halted, strobes()},
                    {26'd0, 2'b10, (s.kind == K_ALU), 3'b000});
        @(posedge clk); #1;
        if (s.kind == K_LOAD || s.kind == K_STORE) begin
            for (int k = 0; k <= s.ackDelay; k++) begin
                mem_ack = (k == s.ackDelay);
                start   = 1'($urandom_range(0, 1));
                @(negedge clk);
                checkOutput("memCtl", {26'd0, busy, md, strobes()},
                            {26'd0, 2'b11, (s.kind == K_LOAD && k == s.ackDelay),
                             (s.kind == K_STORE), 2'b11});
                @(posedge clk); #1;
            end
            mem_ack = 1'b0;
        end else if (s.kind == K_HALT) begin
            start = 1'b0;
            @(negedge clk);
            checkOutput("haltEntry", {18'd0, halted, busy, rom_addr, strobes()},
                        {18'd0, 2'b10, s.pc, 4'b0000});
            @(posedge clk); #1;
        end
    endtask

    step_t vecs [11];
    step_t s;
    logic [7:0] pc;
    logic [7:0] bzExpect [2];

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = mk(16'h2123, 1'b0, 0, 4'h1, 4'h2, 4'h3, 3'b010, 1'b0, 1'b0, K_ALU,   8'd1);
        vecs[1]  = mk(16'h8456, 1'b0, 0, 4'h4, 4'h5, 4'h6, 3'b000, 1'b1, 1'b0, K_ALU,   8'd1);
        vecs[2]  = mk(16'h7ABC, 1'b0, 0, 4'hA, 4'hB, 4'hC, 3'b111, 1'b0, 1'b0, K_ALU,   8'd1);
        vecs[3]  = mk(16'h9450, 1'b0, 3, 4'h4, 4'h5, 4'h0, 3'b000, 1'b0, 1'b1, K_LOAD,  8'd1);
        vecs[4]  = mk(16'hA450, 1'b0, 0, 4'h4, 4'h5, 4'h0, 3'b000, 1'b0, 1'b1, K_STORE, 8'd1);
        vecs[5]  = mk(16'hD000, 1'b1, 0, 4'h0, 4'h0, 4'h0, 3'b000, 1'b0, 1'b0, K_NONE,  8'd1);
        vecs[6]  = mk(16'hE123, 1'b0, 0, 4'h1, 4'h2, 4'h3, 3'b000, 1'b0, 1'b0, K_NONE,  8'd1);
        vecs[7]  = mk(16'hC042, 1'b0, 0, 4'h0, 4'h4, 4'h2, 3'b000, 1'b0, 1'b0, K_NONE,
                      BRANCH_EN ? 8'h42 : 8'h01);
        vecs[8]  = mk(16'hB003, 1'b1, 0, 4'h0, 4'h0, 4'h3, 3'b000, 1'b0, 1'b0, K_NONE,
                      BRANCH_EN ? 8'h03 : 8'h01);
        vecs[9]  = mk(16'hB003, 1'b0, 0, 4'h0, 4'h0, 4'h3, 3'b000, 1'b0, 1'b0, K_NONE,  8'd1);
        vecs[10] = mk(16'h0FFF, 1'b0, 0, 4'hF, 4'hF, 4'hF, 3'b000, 1'b0, 1'b0, K_ALU,   8'd1);

        rst_n = 1'b0; start = 1'b0; mem_ack = 1'b0; zero = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 16'hD000;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            rom[0] = vecs[i].word;
            resetAndStart();
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput("nextPc", {24'd0, rom_addr}, {24'd0, vecs[i].nextPc});
            @(posedge clk); #1;
        end

        // BZ at PC 5 with offset -2, taken and not taken.
        for (int i = 0; i < 256; i++) rom[i] = 16'hD000;
        rom[5] = 16'hB0FE;
        bzExpect[0] = 8'd6;
        bzExpect[1] = BRANCH_EN ? 8'd3 : 8'd6;
        for (int z = 0; z < 2; z++) begin
            resetAndStart();
            for (int i = 0; i < 5; i++) applyStimulus(predict(8'(i), rom[i], 1'b0, 0));
            applyStimulus(predict(8'd5, rom[5], 1'(z), 0));
            @(negedge clk);
            checkOutput("bzTarget", {24'd0, rom_addr}, {24'd0, bzExpect[z]});
            @(posedge clk); #1;
        end

        // PC wraps from 0xFF to 0x00 on a NOP.
        rom[5] = 16'hD000;
        resetAndStart();
        for (int i = 0; i < 256; i++) applyStimulus(predict(8'(i), 16'hD000, 1'b0, 0));
        @(negedge clk);
        checkOutput("pcWrap", {24'd0, rom_addr}, 32'd0);
        @(posedge clk); #1;

        // Reset while a load waits for its acknowledge.
        rom[1] = 16'h9450;
        resetAndStart();
        applyStimulus(predict(8'd0, rom[0], 1'b0, 0));
        mem_ack = 1'b0;
        start   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("memWait", {29'd0, mem_req, mm, md}, {29'd0, 3'b111});
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rstMidMem", allOuts(), 32'd0);
        @(posedge clk); #1;
        checkOutput("rstHold", allOuts(), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rstIdle", allOuts(), 32'd0);
        @(posedge clk); #1;

        // Halt at PC 2, then start pulses must be ignored.
        rom[1] = 16'hD000;
        rom[2] = 16'hF123;
        resetAndStart();
        for (int i = 0; i < 3; i++) applyStimulus(predict(8'(i), rom[i], 1'b0, 0));
        for (int c = 0; c < 10; c++) begin
            start   = (c % 2 == 0);
            mem_ack = 1'b1;
            @(negedge clk);
            checkOutput("haltHold", {18'd0, halted, busy, rom_addr, strobes()},
                        {18'd0, 2'b10, 8'd2, 4'b0000});
            @(posedge clk); #1;
        end
        start   = 1'b0;
        mem_ack = 1'b0;

        // Random program (no halts) followed through the instruction-level model.
        for (int i = 0; i < 256; i++) begin
            rom[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
        end
        resetAndStart();
        pc = 8'd0;
        for (int n = 0; n < 200; n++) begin
            s = predict(pc, rom[pc], 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
            applyStimulus(s);
            pc = s.nextPc;
        end
        @(negedge clk);
        checkOutput("randomEndPc", {24'd0, rom_addr}, {24'd0, pc});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
